// File: rtl/rv32im_lsu_pkg.sv
// Shared types and helpers for the rv32im data-side requester: FSM states,
// access size codes, exception causes and the store byte-lane mask.
package rv32im_lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_e;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_X = 2'd3;

   localparam logic [1:0] EXC_MISALIGN = 2'd1;
   localparam logic [1:0] EXC_ACCESS   = 2'd2;
   localparam logic [1:0] EXC_TIMEOUT  = 2'd3;

   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
      logic [3:0] m;
      case (size)
         SZ_B:    m = 4'b0001 << a;
         SZ_H:    m = 4'b0011 << a;
         SZ_W:    m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
      return (size == SZ_X) || ((size == SZ_H) && a[0]) || ((size == SZ_W) && (a != 2'b00));
   endfunction

endpackage

// File: rtl/rv32im_lsu_lane_align.sv
// Combinational byte-lane steering: shifts store data into its lanes with the
// matching write mask, and extracts/extends load data from the returned word.
module rv32im_lsu_lane_align
   import rv32im_lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        store,
   input  logic        zero_ext,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [31:0] req_data,
   output logic [3:0]  req_we,
   output logic [31:0] load_data
);

   logic [4:0]         shamt;
   logic [31:0]        rshift;
   logic signed [7:0]  rb;
   logic signed [15:0] rh;
   logic signed [31:0] rb_sx;
   logic signed [31:0] rh_sx;

   assign shamt    = {addr_lo, 3'b000};
   assign req_data = wdata << shamt;
   assign req_we   = store ? lane_mask(size, addr_lo) : 4'b0000;

   assign rshift = rdata >> shamt;
   assign rb     = rshift[7:0];
   assign rh     = rshift[15:0];
   assign rb_sx  = 32'(rb);
   assign rh_sx  = 32'(rh);

   always_comb begin
      load_data = rshift;
      case (size)
         SZ_B:    load_data = zero_ext ? {24'h0, rshift[7:0]}  : rb_sx;
         SZ_H:    load_data = zero_ext ? {16'h0, rshift[15:0]} : rh_sx;
         default: load_data = rshift;
      endcase
   end

endmodule

// File: rtl/rv32im_lsu_requester.sv
// Data-side initiator: one load/store at a time, alignment check, word-aligned
// dmem request, bounded wait for accept/response, then wb / st_ack / exception.
module rv32im_lsu_requester
   import rv32im_lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic        op_store,
   input  logic [1:0]  op_size,
   input  logic        op_unsigned,
   input  logic [31:0] op_addr,
   input  logic [31:0] op_wdata,
   input  logic [4:0]  op_rd,
   output logic        dmem_req_valid,
   output logic [31:0] dmem_req_addr,
   output logic [31:0] dmem_req_data,
   output logic [3:0]  dmem_req_write_en,
   input  logic        dmem_accept,
   input  logic        dmem_resp_valid,
   input  logic [31:0] dmem_resp_data,
   input  logic        dmem_error,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        st_ack,
   output logic        exc_valid,
   output logic [1:0]  exc_cause,
   output logic [31:0] exc_addr
);

   localparam int unsigned   TW     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   lsu_state_e    state;
   logic [TW-1:0] timer;
   logic          timer_hit;
   logic          in_idle;

   logic          lat_store;
   logic          lat_unsigned;
   logic [1:0]    lat_size;
   logic [31:0]   lat_addr;
   logic [4:0]    lat_rd;

   logic [1:0]    al_size;
   logic [1:0]    al_addr_lo;
   logic          al_store;
   logic          al_zext;
   logic [31:0]   al_req_data;
   logic [3:0]    al_req_we;
   logic [31:0]   al_load_data;

   assign in_idle   = (state == ST_IDLE);
   assign timer_hit = (timer == T_LAST);

   // The aligner forms the request from the live op while idle, and extracts load data from the latched op afterwards.
   assign al_size    = in_idle ? op_size        : lat_size;
   assign al_addr_lo = in_idle ? op_addr[1:0]   : lat_addr[1:0];
   assign al_store   = in_idle ? op_store       : lat_store;
   assign al_zext    = in_idle ? op_unsigned    : lat_unsigned;

   rv32im_lsu_lane_align u_align (
      .size      (al_size),
      .addr_lo   (al_addr_lo),
      .store     (al_store),
      .zero_ext  (al_zext),
      .wdata     (op_wdata),
      .rdata     (dmem_resp_data),
      .req_data  (al_req_data),
      .req_we    (al_req_we),
      .load_data (al_load_data)
   );

   always_ff @(posedge clk) begin
      if (in_idle && op_valid) begin
         lat_store    <= op_store;
         lat_unsigned <= op_unsigned;
         lat_size     <= op_size;
         lat_addr     <= op_addr;
         lat_rd       <= op_rd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= ST_IDLE;
         timer             <= '0;
         op_ready          <= 1'b1;
         dmem_req_valid    <= 1'b0;
         dmem_req_addr     <= '0;
         dmem_req_data     <= '0;
         dmem_req_write_en <= '0;
         wb_valid          <= 1'b0;
         wb_rd             <= '0;
         wb_data           <= '0;
         st_ack            <= 1'b0;
         exc_valid         <= 1'b0;
         exc_cause         <= '0;
         exc_addr          <= '0;
      end else begin
         wb_valid  <= 1'b0;
         st_ack    <= 1'b0;
         exc_valid <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (op_valid) begin
                  op_ready <= 1'b0;
                  if (misaligned(op_size, op_addr[1:0])) begin
                     exc_valid <= 1'b1;
                     exc_cause <= EXC_MISALIGN;
                     exc_addr  <= op_addr;
                     state     <= ST_RESP;
                  end else begin
                     dmem_req_valid    <= 1'b1;
                     dmem_req_addr     <= {op_addr[31:2], 2'b00};
                     dmem_req_data     <= al_req_data;
                     dmem_req_write_en <= al_req_we;
                     timer             <= '0;
                     state             <= ST_REQ;
                  end
               end
            end

            ST_REQ: begin
               if (dmem_accept && (dmem_error || lat_store || dmem_resp_valid)) begin
                  dmem_req_valid <= 1'b0;
                  state          <= ST_RESP;
                  if (dmem_error) begin
                     exc_valid <= 1'b1;
                     exc_cause <= EXC_ACCESS;
                     exc_addr  <= lat_addr;
                  end else if (lat_store) begin
                     st_ack <= 1'b1;
                  end else begin
                     wb_valid <= 1'b1;
                     wb_rd    <= lat_rd;
                     wb_data  <= al_load_data;
                  end
               end else if (timer_hit) begin
                  dmem_req_valid <= 1'b0;
                  exc_valid      <= 1'b1;
                  exc_cause      <= EXC_TIMEOUT;
                  exc_addr       <= lat_addr;
                  state          <= ST_RESP;
               end else begin
                  if (timer != '1) timer <= timer + 1'b1;
                  if (dmem_accept) begin
                     dmem_req_valid <= 1'b0;
                     state          <= ST_WAIT;
                  end
               end
            end

            ST_WAIT: begin
               if (dmem_resp_valid) begin
                  state <= ST_RESP;
                  if (dmem_error) begin
                     exc_valid <= 1'b1;
                     exc_cause <= EXC_ACCESS;
                     exc_addr  <= lat_addr;
                  end else begin
                     wb_valid <= 1'b1;
                     wb_rd    <= lat_rd;
                     wb_data  <= al_load_data;
                  end
               end else if (timer_hit) begin
                  exc_valid <= 1'b1;
                  exc_cause <= EXC_TIMEOUT;
                  exc_addr  <= lat_addr;
                  state     <= ST_RESP;
               end else if (timer != '1) begin
                  timer <= timer + 1'b1;
               end
            end

            ST_RESP: begin
               op_ready <= 1'b1;
               state    <= ST_IDLE;
            end

            default: begin
               op_ready       <= 1'b1;
               dmem_req_valid <= 1'b0;
               state          <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rv32im_lsu_requester.sv
// Bench for rv32im_lsu_requester: directed cases plus randomized ops checked
// against a byte-lane reference model of loads, stores and exceptions.
module tb_rv32im_lsu_requester;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        op_valid = 1'b0;
   logic        op_ready;
   logic        op_store = 1'b0;
   logic [1:0]  op_size = 2'd0;
   logic        op_unsigned = 1'b0;
   logic [31:0] op_addr = 32'h0;
   logic [31:0] op_wdata = 32'h0;
   logic [4:0]  op_rd = 5'd0;
   logic        dmem_req_valid;
   logic [31:0] dmem_req_addr;
   logic [31:0] dmem_req_data;
   logic [3:0]  dmem_req_write_en;
   logic        dmem_accept = 1'b0;
   logic        dmem_resp_valid = 1'b0;
   logic [31:0] dmem_resp_data = 32'h0;
   logic        dmem_error = 1'b0;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        st_ack;
   logic        exc_valid;
   logic [1:0]  exc_cause;
   logic [31:0] exc_addr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rv32im_lsu_requester #(.TIMEOUT_CYCLES(TO)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .op_valid          (op_valid),
      .op_ready          (op_ready),
      .op_store          (op_store),
      .op_size           (op_size),
      .op_unsigned       (op_unsigned),
      .op_addr           (op_addr),
      .op_wdata          (op_wdata),
      .op_rd             (op_rd),
      .dmem_req_valid    (dmem_req_valid),
      .dmem_req_addr     (dmem_req_addr),
      .dmem_req_data     (dmem_req_data),
      .dmem_req_write_en (dmem_req_write_en),
      .dmem_accept       (dmem_accept),
      .dmem_resp_valid   (dmem_resp_valid),
      .dmem_resp_data    (dmem_resp_data),
      .dmem_error        (dmem_error),
      .wb_valid          (wb_valid),
      .wb_rd             (wb_rd),
      .wb_data           (wb_data),
      .st_ack            (st_ack),
      .exc_valid         (exc_valid),
      .exc_cause         (exc_cause),
      .exc_addr          (exc_addr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: pick the addressed bytes arithmetically, then sign-extend by value range.
   function automatic logic [31:0] model_load(input logic [31:0] rdata, input int sz,
                                              input bit uns, input int a);
      longint nb, field, span;
      nb    = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
      span  = longint'(1) << (8 * nb);
      field = (longint'(rdata) >> (8 * a)) % span;
      if (!uns && (field >= (span / 2))) field = field - span;
      return field[31:0];
   endfunction

   function automatic logic [3:0] model_we(input bit st, input int sz, input int a);
      logic [3:0] m;
      int nb;
      m  = 4'b0000;
      nb = 1 << sz;
      for (int i = 0; i < 4; i++)
         if (st && (i >= a) && (i < a + nb)) m[i] = 1'b1;
      return m;
   endfunction

   function automatic bit model_misal(input int sz, input logic [31:0] addr);
      if (sz == 3) return 1'b1;
      return (addr % (32'd1 << sz)) != 32'd0;
   endfunction

   task automatic do_op(input string tag, input bit st, input int sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                        input logic [31:0] rdata, input int acc_dly, input int resp_dly,
                        input bit err);
      int          a, n, comp_c, last_c;
      bit          tmo;
      logic [3:0]  we_exp;
      logic [31:0] data_exp, addr_exp;

      a = int'(addr[1:0]);
      n = 0;
      while (op_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk({tag, ".ready"}, 32'(op_ready), 32'd1);

      op_store    = st;
      op_size     = 2'(sz);
      op_unsigned = uns;
      op_addr     = addr;
      op_wdata    = wdata;
      op_rd       = rd;
      op_valid    = 1'b1;
      tick();
      op_valid    = 1'b0;
      op_store    = 1'($urandom);
      op_size     = 2'($urandom);
      op_unsigned = 1'($urandom);
      op_addr     = $urandom;
      op_wdata    = $urandom;
      op_rd       = 5'($urandom);
      chk({tag, ".busy"}, 32'(op_ready), 32'd0);

      if (model_misal(sz, addr)) begin
         chk({tag, ".mis_exc"}, 32'(exc_valid), 32'd1);
         chk({tag, ".mis_cause"}, 32'(exc_cause), 32'd1);
         chk({tag, ".mis_addr"}, exc_addr, addr);
         chk({tag, ".mis_noreq"}, 32'(dmem_req_valid), 32'd0);
         chk({tag, ".mis_other"}, 32'({wb_valid, st_ack}), 32'd0);
         tick();
         chk({tag, ".mis_noreq2"}, 32'(dmem_req_valid), 32'd0);
         chk({tag, ".mis_done"}, 32'({op_ready, exc_valid}), 32'b10);
         return;
      end

      we_exp   = model_we(st, sz, a);
      data_exp = wdata << (8 * a);
      addr_exp = addr & ~32'h3;
      comp_c   = st ? acc_dly : acc_dly + resp_dly;
      tmo      = (comp_c >= TO);
      last_c   = tmo ? TO - 1 : comp_c;

      for (int c = 0; c <= last_c; c++) begin
         chk({tag, ".req_valid"}, 32'(dmem_req_valid), 32'(c <= acc_dly));
         if (c <= acc_dly) begin
            chk({tag, ".req_addr"}, dmem_req_addr, addr_exp);
            chk({tag, ".req_data"}, dmem_req_data, data_exp);
            chk({tag, ".req_we"}, 32'(dmem_req_write_en), 32'(we_exp));
         end
         chk({tag, ".no_pulse"}, 32'({wb_valid, st_ack, exc_valid}), 32'd0);
         dmem_accept     = (c == acc_dly);
         dmem_resp_valid = !st && (c == acc_dly + resp_dly);
         dmem_resp_data  = dmem_resp_valid ? rdata : $urandom;
         dmem_error      = err && ((((st || resp_dly == 0) && c == acc_dly)) ||
                                   (!st && resp_dly > 0 && c == acc_dly + resp_dly));
         tick();
         dmem_accept     = 1'b0;
         dmem_resp_valid = 1'b0;
         dmem_error      = 1'b0;
         dmem_resp_data  = $urandom;
      end

      chk({tag, ".req_drop"}, 32'(dmem_req_valid), 32'd0);
      if (tmo) begin
         chk({tag, ".tmo_pulses"}, 32'({wb_valid, st_ack, exc_valid}), 32'b001);
         chk({tag, ".tmo_cause"}, 32'(exc_cause), 32'd3);
         chk({tag, ".tmo_addr"}, exc_addr, addr);
      end else if (err) begin
         chk({tag, ".err_pulses"}, 32'({wb_valid, st_ack, exc_valid}), 32'b001);
         chk({tag, ".err_cause"}, 32'(exc_cause), 32'd2);
         chk({tag, ".err_addr"}, exc_addr, addr);
      end else if (st) begin
         chk({tag, ".st_pulses"}, 32'({wb_valid, st_ack, exc_valid}), 32'b010);
      end else begin
         chk({tag, ".ld_pulses"}, 32'({wb_valid, st_ack, exc_valid}), 32'b100);
         chk({tag, ".ld_rd"}, 32'(wb_rd), 32'(rd));
         chk({tag, ".ld_data"}, wb_data, model_load(rdata, sz, uns, a));
      end
      tick();
      chk({tag, ".idle"}, 32'({op_ready, wb_valid, st_ack, exc_valid}), 32'b1000);
   endtask

   initial begin
      bit          r_st, r_uns, r_err;
      int          r_sz, r_acc, r_resp;
      logic [31:0] r_addr;

      // Reset state
      #12;
      chk("rst.op_ready", 32'(op_ready), 32'd1);
      chk("rst.req_valid", 32'(dmem_req_valid), 32'd0);
      chk("rst.pulses", 32'({wb_valid, st_ack, exc_valid}), 32'd0);
      chk("rst.req_addr", dmem_req_addr, 32'd0);
      chk("rst.req_we", 32'(dmem_req_write_en), 32'd0);
      chk("rst.wb_data", wb_data, 32'd0);
      chk("rst.exc", 32'({exc_cause, exc_addr[0]}), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // Directed cases
      do_op("lw_zero_wait", 1'b0, 2, 1'b0, 32'h100, 32'h0, 5'd7, 32'hDEADBEEF, 0, 0, 1'b0);
      chk("lw_zero_wait.value", wb_data, 32'hDEADBEEF);
      do_op("lb_signed", 1'b0, 0, 1'b0, 32'h103, 32'h0, 5'd3, 32'h80FF_0000, 0, 0, 1'b0);
      chk("lb_signed.value", wb_data, 32'hFFFFFF80);
      do_op("lbu", 1'b0, 0, 1'b1, 32'h103, 32'h0, 5'd4, 32'h80FF_0000, 0, 0, 1'b0);
      chk("lbu.value", wb_data, 32'h00000080);
      do_op("sh_upper", 1'b1, 1, 1'b0, 32'h102, 32'h1234, 5'd0, 32'h0, 0, 0, 1'b0);
      do_op("lw_misaligned", 1'b0, 2, 1'b0, 32'h101, 32'h0, 5'd1, 32'h0, 0, 0, 1'b0);
      do_op("lh_misaligned", 1'b0, 1, 1'b0, 32'h203, 32'h0, 5'd1, 32'h0, 0, 0, 1'b0);
      do_op("size3_illegal", 1'b1, 3, 1'b0, 32'h200, 32'h55, 5'd0, 32'h0, 0, 0, 1'b0);
      do_op("sw_accept_late", 1'b1, 2, 1'b0, 32'h3FC, 32'hCAFEF00D, 5'd0, 32'h0, 3, 0, 1'b0);
      do_op("lh_wait", 1'b0, 1, 1'b0, 32'h402, 32'h0, 5'd9, 32'h8001_7FFF, 1, 2, 1'b0);
      do_op("lw_no_accept", 1'b0, 2, 1'b0, 32'h500, 32'h0, 5'd2, 32'h0, 100, 0, 1'b0);
      do_op("lw_no_resp", 1'b0, 2, 1'b0, 32'h504, 32'h0, 5'd2, 32'h0, 2, 100, 1'b0);
      do_op("lw_last_cycle", 1'b0, 2, 1'b0, 32'h508, 32'h0, 5'd5, 32'h1357_9BDF, 3, 4, 1'b0);
      do_op("lw_one_late", 1'b0, 2, 1'b0, 32'h50C, 32'h0, 5'd5, 32'h1357_9BDF, 3, 5, 1'b0);
      do_op("sb_error", 1'b1, 0, 1'b0, 32'h601, 32'hAB, 5'd0, 32'h0, 1, 0, 1'b1);
      do_op("lw_err_accept", 1'b0, 2, 1'b0, 32'h604, 32'h0, 5'd6, 32'h0, 0, 0, 1'b1);
      do_op("lw_err_wait", 1'b0, 2, 1'b0, 32'h608, 32'h0, 5'd6, 32'h0, 0, 2, 1'b1);
      do_op("lw_rd0", 1'b0, 2, 1'b0, 32'h700, 32'h0, 5'd0, 32'h0F0F_0F0F, 0, 1, 1'b0);

      // Reset while waiting for a read response
      op_store = 1'b0; op_size = 2'd2; op_addr = 32'h800; op_rd = 5'd11; op_valid = 1'b1;
      tick();
      op_valid = 1'b0;
      dmem_accept = 1'b1;
      tick();
      dmem_accept = 1'b0;
      tick();
      rst_n = 1'b0;
      #2;
      chk("rst_wait.op_ready", 32'(op_ready), 32'd1);
      chk("rst_wait.req_valid", 32'(dmem_req_valid), 32'd0);
      tick();
      rst_n = 1'b1;
      dmem_resp_valid = 1'b1;
      dmem_accept = 1'b1;
      dmem_resp_data = 32'h1111_2222;
      tick();
      dmem_resp_valid = 1'b0;
      dmem_accept = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("rst_wait.no_pulse", 32'({wb_valid, st_ack, exc_valid}), 32'd0);
         chk("rst_wait.idle", 32'({op_ready, dmem_req_valid}), 32'b10);
         tick();
      end

      // Randomized ops
      for (int k = 0; k < 60; k++) begin
         r_st   = 1'($urandom);
         r_sz   = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
         r_uns  = 1'($urandom);
         r_addr = $urandom;
         if ($urandom_range(0, 3) != 0)
            r_addr = (r_sz == 1) ? (r_addr & ~32'h1) : (r_sz == 2) ? (r_addr & ~32'h3) : r_addr;
         r_acc  = int'($urandom_range(0, 3));
         r_resp = ($urandom_range(0, 9) == 0) ? 6 : int'($urandom_range(0, 3));
         r_err  = ($urandom_range(0, 7) == 0);
         do_op("rand", r_st, r_sz, r_uns, r_addr, $urandom, 5'($urandom), $urandom,
               r_acc, r_resp, r_err);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
